// File: rtl/cnt_threshold_monitor.sv
// Threshold/saturation monitor for an up/down counter value.
// Debounced hysteresis plus edge-detected MAX/ZERO, queued in a small event FIFO.
module cnt_threshold_monitor #(
    parameter int SIZE     = 4,
    parameter int DEBOUNCE = 3,
    parameter int DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] cnt,
    input  logic [SIZE-1:0] hi_th,
    input  logic [SIZE-1:0] lo_th,
    input  logic            clr_ovf,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [1:0]      evt_code,
    output logic            level,
    output logic            overflow
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [SIZE-1:0] CNT_MAX = '1;
    localparam logic [SIZE-1:0] CNT_MIN = '0;
    localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE);
    localparam logic [AW-1:0]   PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    localparam logic [1:0] EV_RISE = 2'b00;
    localparam logic [1:0] EV_FALL = 2'b01;
    localparam logic [1:0] EV_MAX  = 2'b10;
    localparam logic [1:0] EV_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_CHK,
        ST_HIGH,
        ST_FALL_CHK
    } state_t;

    state_t          state_q;
    state_t          state_n;
    logic [DW-1:0]   dcnt_q;
    logic [DW-1:0]   dcnt_n;
    logic [DW-1:0]   dcnt_inc;
    logic            rise_evt;
    logic            fall_evt;

    logic [SIZE-1:0] cnt_q;
    logic            max_evt;
    logic            zero_evt;
    logic            thr_evt;
    logic            sat_evt;
    logic [1:0]      thr_code;
    logic [1:0]      sat_code;

    logic            pend_v_q;
    logic [1:0]      pend_code_q;
    logic            pend_v_n;
    logic [1:0]      pend_code_n;
    logic            push;
    logic [1:0]      push_code;

    logic [1:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            pop;
    logic            wr_en;
    logic            drop;

    logic            ge_hi;
    logic            le_lo;

    assign ge_hi    = (cnt >= hi_th);
    assign le_lo    = (cnt <= lo_th);
    assign dcnt_inc = dcnt_q + DW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOW;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_n;
            dcnt_q  <= dcnt_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        dcnt_n   = dcnt_q;
        rise_evt = 1'b0;
        fall_evt = 1'b0;
        unique case (state_q)
            ST_LOW: begin
                if (ge_hi) begin
                    if (DEBOUNCE == 1) begin
                        state_n  = ST_HIGH;
                        dcnt_n   = '0;
                        rise_evt = 1'b1;
                    end else begin
                        state_n = ST_RISE_CHK;
                        dcnt_n  = DW'(1);
                    end
                end
            end
            ST_RISE_CHK: begin
                if (ge_hi) begin
                    if (dcnt_inc == DB_LAST) begin
                        state_n  = ST_HIGH;
                        dcnt_n   = '0;
                        rise_evt = 1'b1;
                    end else begin
                        dcnt_n = dcnt_inc;
                    end
                end else begin
                    state_n = ST_LOW;
                    dcnt_n  = '0;
                end
            end
            ST_HIGH: begin
                if (le_lo) begin
                    if (DEBOUNCE == 1) begin
                        state_n  = ST_LOW;
                        dcnt_n   = '0;
                        fall_evt = 1'b1;
                    end else begin
                        state_n = ST_FALL_CHK;
                        dcnt_n  = DW'(1);
                    end
                end
            end
            ST_FALL_CHK: begin
                if (le_lo) begin
                    if (dcnt_inc == DB_LAST) begin
                        state_n  = ST_LOW;
                        dcnt_n   = '0;
                        fall_evt = 1'b1;
                    end else begin
                        dcnt_n = dcnt_inc;
                    end
                end else begin
                    state_n = ST_HIGH;
                    dcnt_n  = '0;
                end
            end
            default: begin
                state_n = ST_LOW;
                dcnt_n  = '0;
            end
        endcase
    end

    assign level = (state_q == ST_HIGH) || (state_q == ST_FALL_CHK);

    // cnt_q resets to zero, so a count parked at zero never reports ZERO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt;
        end
    end

    assign max_evt  = (cnt == CNT_MAX) && (cnt_q != CNT_MAX);
    assign zero_evt = (cnt == CNT_MIN) && (cnt_q != CNT_MIN);
    assign thr_evt  = rise_evt || fall_evt;
    assign sat_evt  = max_evt || zero_evt;
    assign thr_code = rise_evt ? EV_RISE : EV_FALL;
    assign sat_code = max_evt ? EV_MAX : EV_ZERO;

    // One push per cycle: threshold first, then a parked saturation event
    always_comb begin
        push        = 1'b0;
        push_code   = EV_RISE;
        pend_v_n    = pend_v_q;
        pend_code_n = pend_code_q;
        if (thr_evt) begin
            push      = 1'b1;
            push_code = thr_code;
            if (sat_evt) begin
                pend_v_n    = 1'b1;
                pend_code_n = sat_code;
            end
        end else if (pend_v_q) begin
            push        = 1'b1;
            push_code   = pend_code_q;
            pend_v_n    = sat_evt;
            pend_code_n = sat_evt ? sat_code : pend_code_q;
        end else if (sat_evt) begin
            push      = 1'b1;
            push_code = sat_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_q    <= 1'b0;
            pend_code_q <= EV_RISE;
        end else begin
            pend_v_q    <= pend_v_n;
            pend_code_q <= pend_code_n;
        end
    end

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign pop   = !empty && evt_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

    // A drop in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign evt_valid = !empty;
    assign evt_code  = empty ? EV_RISE : mem[rd_ptr];

endmodule

// File: tb/tb_cnt_threshold_monitor.sv
// Directed bench for cnt_threshold_monitor.
// Main instance uses DEBOUNCE=3; a second instance covers DEBOUNCE=1.
module tb_cnt_threshold_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt;
    logic [3:0] hi_th;
    logic [3:0] lo_th;
    logic       clr_ovf;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       level;
    logic       overflow;

    logic [3:0] d_cnt;
    logic [3:0] d_hi_th;
    logic [3:0] d_lo_th;
    logic       d_clr_ovf;
    logic       d_evt_ready;
    logic       d_evt_valid;
    logic [1:0] d_evt_code;
    logic       d_level;
    logic       d_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnt_threshold_monitor #(.SIZE(4), .DEBOUNCE(3), .DEPTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt),
        .hi_th     (hi_th),
        .lo_th     (lo_th),
        .clr_ovf   (clr_ovf),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .level     (level),
        .overflow  (overflow)
    );

    cnt_threshold_monitor #(.SIZE(4), .DEBOUNCE(1), .DEPTH(4)) u_d1 (
        .clk       (clk),
        .rst       (rst),
        .cnt       (d_cnt),
        .hi_th     (d_hi_th),
        .lo_th     (d_lo_th),
        .clr_ovf   (d_clr_ovf),
        .evt_ready (d_evt_ready),
        .evt_valid (d_evt_valid),
        .evt_code  (d_evt_code),
        .level     (d_level),
        .overflow  (d_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [1:0] c, input logic l,
                           input logic o);
        chk({tag, ".valid"}, {3'b0, evt_valid}, {3'b0, v});
        chk({tag, ".code"}, {2'b0, evt_code}, {2'b0, c});
        chk({tag, ".level"}, {3'b0, level}, {3'b0, l});
        chk({tag, ".ovf"}, {3'b0, overflow}, {3'b0, o});
    endtask

    initial begin
        rst = 1'b1;
        cnt = 4'd0;
        hi_th = 4'd10;
        lo_th = 4'd5;
        clr_ovf = 1'b0;
        evt_ready = 1'b0;
        d_cnt = 4'd0;
        d_hi_th = 4'd15;
        d_lo_th = 4'd5;
        d_clr_ovf = 1'b0;
        d_evt_ready = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 2'b00, 1'b0, 1'b0);
        chk("reset.d1valid", {3'b0, d_evt_valid}, 4'd0);
        rst = 1'b0;
        step();
        chk_out("zero_hold", 1'b0, 2'b00, 1'b0, 1'b0);

        // glitch: 9,10,11,9,9 must not confirm
        cnt = 4'd9;  step();
        cnt = 4'd10; step();
        cnt = 4'd11; step();
        chk_out("glitch_chk", 1'b0, 2'b00, 1'b0, 1'b0);
        cnt = 4'd9;  step();
        cnt = 4'd9;  step();
        chk_out("glitch_end", 1'b0, 2'b00, 1'b0, 1'b0);
        cnt = 4'd10; step();
        cnt = 4'd11; step();
        chk_out("relow_11", 1'b0, 2'b00, 1'b0, 1'b0);
        cnt = 4'd12; step();
        chk_out("relow_12", 1'b1, 2'b00, 1'b1, 1'b0);

        // restart from clean state
        rst = 1'b1;
        cnt = 4'd0;
        #1;
        chk_out("async_rst", 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // ramp up 0..15
        for (int v = 0; v < 16; v++) begin
            cnt = 4'(v);
            step();
            if (v == 11) chk_out("up_11", 1'b0, 2'b00, 1'b0, 1'b0);
            if (v == 12) chk_out("up_12", 1'b1, 2'b00, 1'b1, 1'b0);
        end
        chk_out("up_15", 1'b1, 2'b00, 1'b1, 1'b0);

        // ramp down 14..0: FALL at 3, ZERO at 0
        for (int v = 14; v >= 0; v--) begin
            cnt = 4'(v);
            step();
            if (v == 4) chk_out("dn_4", 1'b1, 2'b00, 1'b1, 1'b0);
            if (v == 3) chk_out("dn_3", 1'b1, 2'b00, 1'b0, 1'b0);
        end
        chk_out("dn_0", 1'b1, 2'b00, 1'b0, 1'b0);

        // ramp up again: FIFO full, RISE and MAX dropped
        for (int v = 1; v < 15; v++) begin
            cnt = 4'(v);
            step();
            if (v == 11) chk_out("up2_11", 1'b1, 2'b00, 1'b0, 1'b0);
            if (v == 12) chk_out("up2_12", 1'b1, 2'b00, 1'b1, 1'b1);
        end
        clr_ovf = 1'b0;
        step();
        cnt = 4'd15;
        clr_ovf = 1'b1;
        step();
        chk_out("clr_and_drop", 1'b1, 2'b00, 1'b1, 1'b1);
        step();
        chk_out("clr_ovf", 1'b1, 2'b00, 1'b1, 1'b0);
        clr_ovf = 1'b0;

        // full FIFO, FALL raised while popping
        for (int v = 14; v >= 4; v--) begin
            cnt = 4'(v);
            step();
        end
        cnt = 4'd3;
        evt_ready = 1'b1;
        step();
        chk_out("full_pop_push", 1'b1, 2'b10, 1'b0, 1'b0);
        step();
        chk_out("drain_1", 1'b1, 2'b01, 1'b0, 1'b0);
        step();
        chk_out("drain_2", 1'b1, 2'b11, 1'b0, 1'b0);
        step();
        chk_out("drain_3", 1'b1, 2'b01, 1'b0, 1'b0);
        step();
        chk_out("drain_4", 1'b0, 2'b00, 1'b0, 1'b0);
        evt_ready = 1'b0;

        // two events queued while in RISE_CHK, then reset
        cnt = 4'd0;
        step();
        chk_out("q_zero", 1'b1, 2'b11, 1'b0, 1'b0);
        cnt = 4'd15;
        step();
        chk_out("q_max", 1'b1, 2'b11, 1'b0, 1'b0);
        rst = 1'b1;
        cnt = 4'd0;
        #1;
        chk_out("rst_chk", 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("post_rst", 1'b0, 2'b00, 1'b0, 1'b0);
        end

        // DEBOUNCE=1: RISE and MAX on the same edge
        for (int v = 0; v < 16; v++) begin
            d_cnt = 4'(v);
            step();
        end
        chk("d1_rise.valid", {3'b0, d_evt_valid}, 4'd1);
        chk("d1_rise.code", {2'b0, d_evt_code}, 4'd0);
        chk("d1_rise.level", {3'b0, d_level}, 4'd1);
        d_evt_ready = 1'b1;
        step();
        chk("d1_max.valid", {3'b0, d_evt_valid}, 4'd1);
        chk("d1_max.code", {2'b0, d_evt_code}, 4'd2);
        step();
        chk("d1_empty.valid", {3'b0, d_evt_valid}, 4'd0);
        chk("d1_ovf", {3'b0, d_overflow}, 4'd0);
        d_evt_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
